// File: rtl/cmp_result_tally.sv
// Tallies comparator results (lt/gt/eq, running max of a/b) over WINDOW samples; CMP_ONEHOT_CHECK_EN adds one-hot flag checking.
// Latency: summary valid one cycle after the WINDOW-th accepted sample.
// Backpressure: in_ready drops while a summary is held; it returns the cycle after out_ready is seen.
module cmp_result_tally #(
  parameter int N      = 8,
  parameter int WINDOW = 10,
  parameter int CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          lesser,
  input  logic          greater,
  input  logic          equal,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] lt_count,
  output logic [CW-1:0] gt_count,
  output logic [CW-1:0] eq_count,
  output logic [N-1:0]  win_max,
  output logic          flag_err
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  typedef struct packed {
    logic [CW-1:0] lt;
    logic [CW-1:0] gt;
    logic [CW-1:0] eq;
    logic [N-1:0]  mx;
    logic          err;
  } tally_t;

  state_t     state_q, state_d;
  logic [7:0] idx_q, idx_d;
  tally_t     tally_q, tally_d;

  logic       inc_lt, inc_gt, inc_eq, bad_flags;
  logic [N-1:0] ab_max;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

`ifdef CMP_ONEHOT_CHECK_EN
  always_comb begin
    inc_lt    = ({lesser, greater, equal} == 3'b100);
    inc_gt    = ({lesser, greater, equal} == 3'b010);
    inc_eq    = ({lesser, greater, equal} == 3'b001);
    bad_flags = !(inc_lt || inc_gt || inc_eq);
  end
`else
  // Without checking, flags are resolved by priority equal > lesser > greater.
  always_comb begin
    inc_eq    = equal;
    inc_lt    = lesser && !equal;
    inc_gt    = greater && !equal && !lesser;
    bad_flags = 1'b0;
  end
`endif

  assign ab_max = (a > b) ? a : b;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    tally_d = tally_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (inc_lt) tally_d.lt = sat_inc(tally_q.lt);
          if (inc_gt) tally_d.gt = sat_inc(tally_q.gt);
          if (inc_eq) tally_d.eq = sat_inc(tally_q.eq);
          tally_d.err = tally_q.err || bad_flags;
          if (ab_max > tally_q.mx) tally_d.mx = ab_max;
          if (idx_q == 8'(WINDOW - 1)) begin
            state_d = HOLD;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = ACCUM;
          idx_d   = '0;
          tally_d = '0;
        end
      end
      default: begin
        state_d = ACCUM;
        idx_d   = '0;
        tally_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      tally_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      tally_q <= tally_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign lt_count  = tally_q.lt;
  assign gt_count  = tally_q.gt;
  assign eq_count  = tally_q.eq;
  assign win_max   = tally_q.mx;
  assign flag_err  = tally_q.err;

endmodule
